// File: rtl/lcd_sequencer.sv
// lcd_sequencer: arbitrates two write requesters onto an HD44780 8-bit bus
// and generates the E strobe with setup / pulse / hold / execution timing.
// Optional feature: define LCD_SEQ_INIT_EN to add the power-up wait and the
// built-in panel init sequence (0x38,0x38,0x38,0x0C,0x01,0x06).
module lcd_sequencer #(
    parameter int SETUP_CYC   = 2,
    parameter int PULSE_CYC   = 12,
    parameter int HOLD_CYC    = 2,
    parameter int EXEC_CYC    = 2000,
    parameter int CLEAR_CYC   = 80000,
    parameter int POWERUP_CYC = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared phase counter, wide enough for the longest phase so it never wraps.
    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, PULSE_CYC), max2(HOLD_CYC, EXEC_CYC)),
                                  max2(CLEAR_CYC, POWERUP_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYC - 1);

`ifdef LCD_SEQ_INIT_EN
    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYC - 1);

    typedef enum logic [2:0] {INIT, IDLE, SETUP, PULSE, HOLD, EXEC} state_t;
    localparam state_t RESET_STATE = INIT;

    // Panel init command bytes, all sent with rs=0.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            default:          return 8'h06;
        endcase
    endfunction
`else
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_q, e_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             grant1;
    logic             is_clear;
    logic [CNT_W-1:0] exec_last;

`ifdef LCD_SEQ_INIT_EN
    logic [2:0]       init_idx_q, init_idx_d;
    logic             init_act_q, init_act_d;
    logic             init_done_q, init_done_d;
`endif

    // Round-robin pick: requester 1 wins when it is alone or when 0 was served last.
    assign grant1    = req1 && (!req0 || !last_q);
    // Clear/home commands need the long execution wait.
    assign is_clear  = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
    assign exec_last = is_clear ? CLEAR_LAST : EXEC_LAST;

    // Next-state, counter, latch and ack decode for the write sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        rs_d     = rs_q;
        data_d   = data_q;
        owner_d  = owner_q;
        last_d   = last_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
`ifdef LCD_SEQ_INIT_EN
        init_idx_d  = init_idx_q;
        init_act_d  = init_act_q;
        init_done_d = init_done_q;
`endif
        case (state_q)
`ifdef LCD_SEQ_INIT_EN
            INIT: begin
                if (cnt_q == POWERUP_LAST) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    rs_d    = 1'b0;
                    data_d  = init_byte(3'd0);
                end
            end
`endif
            IDLE: begin
                cnt_d = '0;
                if (req0 || req1) begin
                    state_d = SETUP;
                    owner_d = grant1;
                    last_d  = grant1;
                    rs_d    = grant1 ? rs1 : rs0;
                    data_d  = grant1 ? data1 : data0;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = EXEC;
                    cnt_d   = '0;
                end
            end
            EXEC: begin
                if (cnt_q == exec_last) begin
                    cnt_d = '0;
`ifdef LCD_SEQ_INIT_EN
                    if (init_act_q) begin
                        if (init_idx_q == 3'd5) begin
                            state_d     = IDLE;
                            init_act_d  = 1'b0;
                            init_done_d = 1'b1;
                        end else begin
                            state_d    = SETUP;
                            init_idx_d = init_idx_q + 3'd1;
                            data_d     = init_byte(init_idx_q + 3'd1);
                        end
                    end else begin
                        state_d = IDLE;
                        ack0_d  = !owner_q;
                        ack1_d  = owner_q;
                    end
`else
                    state_d = IDLE;
                    ack0_d  = !owner_q;
                    ack1_d  = owner_q;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // E is registered from the next state so it is glitch-free on the pin.
    always_comb begin
        e_d = (state_d == PULSE);
    end

    // State and output registers; reset drops E and the bus asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

`ifdef LCD_SEQ_INIT_EN
    // Init sequence progress; init_done stays set until the next reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_idx_q  <= 3'd0;
            init_act_q  <= 1'b1;
            init_done_q <= 1'b0;
        end else begin
            init_idx_q  <= init_idx_d;
            init_act_q  <= init_act_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;
`else
    assign init_done = 1'b1;
`endif

    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_data = data_q;
    assign lcd_rw   = 1'b0;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: randomized and directed bench for lcd_sequencer, checked
// every cycle against a transaction-timeline model of the write protocol.
module tb_lcd_sequencer;

    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int X  = 10;
    localparam int C  = 40;
    localparam int PW = 100;
    localparam int NEVER = 32'h7fff_ffff;

`ifdef LCD_SEQ_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, lcd_e, lcd_rs, lcd_rw, busy, init_done;
    logic [7:0] lcd_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] init_bytes [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    always #5 clk = ~clk;

    lcd_sequencer #(
        .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
        .EXEC_CYC(X), .CLEAR_CYC(C), .POWERUP_CYC(PW)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
        .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
        .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data),
        .busy(busy), .init_done(init_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // ---------------- behavioural timeline model ----------------
    // A transaction granted at edge g with length T shows E on edges g+S..g+S+P-1,
    // busy on edges g..g+T-1, and the ack on edge g+T; next grant no sooner than g+T+1.
    int         n = 0;
    bit         m_in_rst = 1'b1;
    bit         have = 1'b0, t_init = 1'b0, m_owner = 1'b0, m_last = 1'b1;
    int         g = 0, t_len = 0, free_at = NEVER, init_idx = 0, init_at = -1;
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         m_init_busy = INIT_EN, m_init_done = !INIT_EN;
    bit         exp_e = 1'b0, exp_busy = 1'b0, exp_ack0 = 1'b0, exp_ack1 = 1'b0;

    function automatic int txn_len(input logic rs, input logic [7:0] d);
        return S + P + H + ((!rs && d >= 8'h01 && d <= 8'h03) ? C : X);
    endfunction

    task automatic start_init(input int idx);
        have   = 1'b1;
        t_init = 1'b1;
        g      = n;
        m_rs   = 1'b0;
        m_data = init_bytes[idx];
        t_len  = txn_len(1'b0, init_bytes[idx]);
    endtask

    task automatic model_step();
        int  k;
        bit  w;
        n++;
        if (!reset) begin
            m_in_rst    = 1'b1;
            have        = 1'b0;
            m_rs        = 1'b0;
            m_data      = 8'h00;
            m_last      = 1'b1;
            free_at     = NEVER;
            init_at     = -1;
            m_init_busy = INIT_EN;
            m_init_done = !INIT_EN;
        end else begin
            if (m_in_rst) begin
                m_in_rst = 1'b0;
                if (INIT_EN) begin
                    init_idx = 0;
                    init_at  = n + PW - 1;
                end else begin
                    free_at = n;
                end
            end
            if (INIT_EN) begin
                if (n == init_at) begin
                    start_init(0);
                end else if (have && t_init && n == g + t_len && m_init_busy) begin
                    if (init_idx < 5) begin
                        init_idx++;
                        start_init(init_idx);
                    end else begin
                        m_init_busy = 1'b0;
                        m_init_done = 1'b1;
                        free_at     = n + 1;
                    end
                end
            end
            if (n >= free_at && (req0 || req1)) begin
                w       = req1 && (!req0 || !m_last);
                m_owner = w;
                m_last  = w;
                m_rs    = w ? rs1 : rs0;
                m_data  = w ? data1 : data0;
                have    = 1'b1;
                t_init  = 1'b0;
                g       = n;
                t_len   = txn_len(m_rs, m_data);
                free_at = n + t_len + 1;
            end
        end
        k        = n - g;
        exp_e    = have && k >= S && k < S + P;
        exp_busy = m_init_busy || (have && k < t_len);
        exp_ack0 = have && !t_init && k == t_len && !m_owner;
        exp_ack1 = have && !t_init && k == t_len && m_owner;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare every output against the model (or reset values) on each falling edge.
    task automatic check_output();
        if (!reset) begin
            chk("rst_e", lcd_e, 0);
            chk("rst_rs", lcd_rs, 0);
            chk("rst_data", lcd_data, 0);
            chk("rst_rw", lcd_rw, 0);
            chk("rst_ack0", ack0, 0);
            chk("rst_ack1", ack1, 0);
            chk("rst_busy", busy, INIT_EN);
            chk("rst_init_done", init_done, !INIT_EN);
        end else begin
            chk("lcd_e", lcd_e, exp_e);
            chk("lcd_rs", lcd_rs, m_rs);
            chk("lcd_data", lcd_data, m_data);
            chk("lcd_rw", lcd_rw, 0);
            chk("ack0", ack0, exp_ack0);
            chk("ack1", ack1, exp_ack1);
            chk("busy", busy, exp_busy);
            chk("init_done", init_done, m_init_done);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check_output();
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        if (!ok) fail_timeout("wait_idle");
    endtask

    task automatic single_write(input bit who, input logic rs, input logic [7:0] d,
                                input int exp_ack, input bit change_in);
        int j, e_rise, e_cnt, ack_at, other_acks, held_bad;
        bit got;
        wait_idle();
        @(negedge clk);
        if (!who) begin req0 = 1'b1; rs0 = rs; data0 = d; end
        else      begin req1 = 1'b1; rs1 = rs; data1 = d; end
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (busy) got = 1'b1;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!got) begin
            fail_timeout("write_grant");
            return;
        end
        if (change_in) begin
            if (!who) data0 = d + 8'd1;
            else      data1 = d + 8'd1;
        end
        e_rise = -1; e_cnt = 0; ack_at = -1; other_acks = 0; held_bad = 0; j = 0;
        while (ack_at < 0 && j < 200) begin
            if (lcd_e) begin
                e_cnt++;
                if (e_rise < 0) e_rise = j;
            end
            if (who ? ack0 : ack1) other_acks++;
            if (who ? ack1 : ack0) ack_at = j;
            if (lcd_data !== d) held_bad++;
            if (ack_at < 0) begin
                @(negedge clk);
                j++;
            end
        end
        if (ack_at < 0) begin
            fail_timeout("write_ack");
            return;
        end
        chk($sformatf("e_rise_offset_%0h", d), e_rise, S);
        chk($sformatf("e_high_clocks_%0h", d), e_cnt, P);
        chk($sformatf("ack_offset_%0h", d), ack_at, exp_ack);
        chk($sformatf("other_ack_%0h", d), other_acks, 0);
        chk($sformatf("data_held_%0h", d), held_bad, 0);
    endtask

    task automatic contention();
        int seq[$];
        wait_idle();
        @(negedge clk);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'hA0;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'hB1;
        for (int t = 0; t < 300 && seq.size() < 4; t++) begin
            @(negedge clk);
            if (ack0) seq.push_back(0);
            if (ack1) seq.push_back(1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (seq.size() < 4) fail_timeout("contention");
        else for (int i = 0; i < 4; i++) chk($sformatf("contention_order_%0d", i), seq[i], i % 2);
    endtask

    task automatic reset_mid_pulse();
        bit got = 1'b0;
        int acks = 0;
        wait_idle();
        @(negedge clk);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h5A;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (lcd_e) got = 1'b1;
        end
        req0 = 1'b0;
        if (!got) fail_timeout("pulse_before_abort");
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_e", lcd_e, 0);
        chk("abort_data", lcd_data, 0);
        chk("abort_rs", lcd_rs, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (ack0 || ack1) acks++;
        end
        chk("abort_no_ack", acks, 0);
    endtask

    task automatic init_check();
        logic [7:0] bytes[$];
        bit prev_e = 1'b0, acked = 1'b0;
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h33;
        for (int t = 0; t < 3000 && !acked; t++) begin
            @(negedge clk);
            if (lcd_e && !prev_e) begin
                bytes.push_back(lcd_data);
                if (bytes.size() == 7) chk("init_done_before_user", init_done, 1);
            end
            prev_e = lcd_e;
            if (ack0) acked = 1'b1;
        end
        req0 = 1'b0;
        if (!acked || bytes.size() != 7) fail_timeout("init_sequence");
        else begin
            for (int i = 0; i < 6; i++) chk($sformatf("init_byte_%0d", i), bytes[i], init_bytes[i]);
            chk("user_after_init", bytes[6], 8'h33);
        end
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 5))
            0: return 8'h01;
            1: return 8'h02;
            2: return 8'h03;
            3: return 8'h80;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic apply_stimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            req0  = ($urandom_range(0, 3) == 0);
            req1  = ($urandom_range(0, 3) == 0);
            rs0   = ($urandom_range(0, 2) != 0);
            rs1   = ($urandom_range(0, 2) != 0);
            data0 = pick_byte();
            data1 = pick_byte();
        end
        @(negedge clk);
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        if (INIT_EN) init_check();
        single_write(1'b0, 1'b1, 8'h41, 18, 1'b1);
        single_write(1'b0, 1'b0, 8'h01, 48, 1'b0);
        single_write(1'b0, 1'b0, 8'h80, 18, 1'b0);
        single_write(1'b1, 1'b0, 8'h02, 48, 1'b1);
        single_write(1'b1, 1'b0, 8'h03, 48, 1'b0);
        single_write(1'b0, 1'b0, 8'h04, 18, 1'b0);
        single_write(1'b1, 1'b1, 8'h01, 18, 1'b0);
        reset_mid_pulse();
        contention();
        apply_stimulus(3000);
        wait_idle();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
